// File: rtl/ddr4_cal_config_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ddr4_cal_config_pkg : entry layout, opcodes and sequencer state encoding  |
// | rev 1.0                                                                   |
// +----------------------------------------------------------------------------+
package ddr4_cal_config_pkg;

  localparam int BL_W  = 8;
  localparam int OP_W  = 8;
  localparam int ADR_W = 16;

  localparam logic [OP_W-1:0] OP_END = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Field order fixes the bit offsets: burst_len[31:24], op[23:16], addr[15:0].
  typedef struct packed {
    logic [BL_W-1:0]  burst_len;
    logic [OP_W-1:0]  op;
    logic [ADR_W-1:0] addr;
  } cal_entry_t;

  function automatic logic [BL_W-1:0] beats_of(input logic [BL_W-1:0] bl);
    return (bl == '0) ? BL_W'(1) : bl;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ddr4_cal_config_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ddr4_cal_config_mem : reset-loaded config array, one write port, two       |
// | registered read-first read ports (random access + sequencer fetch). r1.0  |
// +----------------------------------------------------------------------------+
module ddr4_cal_config_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64,
  parameter logic [DEPTH*DATA_WIDTH-1:0] INIT_WORDS = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  fetch_en,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [DATA_WIDTH-1:0] fetch_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [DATA_WIDTH-1:0] fetch_data_q, fetch_data_d;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a) < $unsigned(DEPTH);
  endfunction

  // Both reads use mem_q, so a same-cycle write is only visible a cycle later.
  always_comb begin
    mem_d = mem_q;
    if (wr_en && in_range(wr_addr)) mem_d[wr_addr] = wr_data;
    rd_data_d = in_range(rd_addr) ? mem_q[rd_addr] : '0;
    fetch_data_d = fetch_data_q;
    if (fetch_en) fetch_data_d = in_range(fetch_addr) ? mem_q[fetch_addr] : '0;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= INIT_WORDS[i*DATA_WIDTH +: DATA_WIDTH];
      rd_data_q    <= '0;
      fetch_data_q <= '0;
    end else begin
      mem_q        <= mem_d;
      rd_data_q    <= rd_data_d;
      fetch_data_q <= fetch_data_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign fetch_data = fetch_data_q;

endmodule
`default_nettype wire

// File: rtl/ddr4_cal_config_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ddr4_cal_config_seq : calibration config store with entry-walking beat     |
// | sequencer feeding the cal engine over valid/ready.              rev 1.0   |
// +----------------------------------------------------------------------------+
module ddr4_cal_config_seq
  import ddr4_cal_config_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64,
  parameter logic [DEPTH*DATA_WIDTH-1:0] INIT_WORDS = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] dout_o,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  abort,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OP_W-1:0]       out_op,
  output logic [ADR_W-1:0]      out_addr,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  logic [DATA_WIDTH-1:0] fetch_data;
  logic                  fetch_en;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  cal_entry_t            fetch_entry;

  seq_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [BL_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [BL_W-1:0]       beats_q, beats_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [OP_W-1:0]       out_op_q, out_op_d;
  logic [ADR_W-1:0]      out_addr_q, out_addr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  ptr_at_end;

  ddr4_cal_config_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .INIT_WORDS (INIT_WORDS)
  ) u_mem (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (dout_o),
    .fetch_en   (fetch_en),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data)
  );

  assign fetch_entry = cal_entry_t'(fetch_data);
  assign ptr_at_end  = ptr_q >= ADDR_WIDTH'(DEPTH - 1);

  // The entry is snapshotted into the fetch register on the edge that enters
  // FETCH and held until the next entry is requested, so patches to the entry
  // being issued never disturb its in-flight beats.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    beat_cnt_d  = beat_cnt_q;
    beats_d     = beats_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_op_d    = out_op_q;
    out_addr_d  = out_addr_q;
    err_d       = err_q;
    fetch_en    = 1'b0;
    fetch_addr  = ptr_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_FETCH;
          ptr_d      = start_addr;
          err_d      = 1'b0;
          fetch_en   = 1'b1;
          fetch_addr = start_addr;
        end
      end
      ST_FETCH: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (fetch_entry.op == OP_END) begin
          state_d = ST_DONE;
        end else begin
          state_d     = ST_ISSUE;
          beat_cnt_d  = '0;
          beats_d     = beats_of(fetch_entry.burst_len);
          out_valid_d = 1'b1;
          out_op_d    = fetch_entry.op;
          out_addr_d  = fetch_entry.addr;
          out_last_d  = (fetch_entry.burst_len <= BL_W'(1));
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end else if (out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            if (ptr_at_end) begin
              state_d = ST_IDLE;
              err_d   = 1'b1;
            end else begin
              state_d    = ST_FETCH;
              ptr_d      = ptr_q + ADDR_WIDTH'(1);
              fetch_en   = 1'b1;
              fetch_addr = ptr_q + ADDR_WIDTH'(1);
            end
          end else begin
            beat_cnt_d = beat_cnt_q + BL_W'(1);
            out_addr_d = out_addr_q + ADR_W'(1);
            out_last_d = (beat_cnt_q + BL_W'(1)) == (beats_q - BL_W'(1));
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      beat_cnt_q  <= '0;
      beats_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_op_q    <= '0;
      out_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      beats_q     <= beats_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_op_q    <= out_op_d;
      out_addr_q  <= out_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_op    = out_op_q;
  assign out_addr  = out_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr4_cal_config_seq.sv
`default_nettype none
// tb_ddr4_cal_config_seq: read-port vector table, directed sequencer corners and a
// randomised entry walk checked against a list-building model of the sequencer.
module tb_ddr4_cal_config_seq;

  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int DEPTH = 64;
  localparam logic [7:0] END_OP = 8'hFF;

  function automatic logic [DEPTH*DW-1:0] mk_init();
    logic [DEPTH*DW-1:0] v;
    v = '0;
    v[5*DW  +: DW] = 32'h0312_0040;
    v[6*DW  +: DW] = 32'h00FF_0000;
    v[10*DW +: DW] = 32'h0007_FFFF;
    v[11*DW +: DW] = 32'h0208_FFFF;
    v[12*DW +: DW] = 32'h00FF_0000;
    v[20*DW +: DW] = 32'h0A05_0100;
    v[21*DW +: DW] = 32'h00FF_0000;
    v[63*DW +: DW] = 32'h0109_1234;
    return v;
  endfunction
  localparam logic [DEPTH*DW-1:0] INIT = mk_init();

  logic          clk_i = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rd_addr, wr_addr, start_addr;
  logic [DW-1:0] dout_o, wr_data;
  logic          wr_en, start, abort, out_valid, out_ready, out_last, busy, done, err;
  logic [7:0]    out_op;
  logic [15:0]   out_addr;

  ddr4_cal_config_seq #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .INIT_WORDS (INIT)
  ) dut (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .rd_addr    (rd_addr),
    .dout_o     (dout_o),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .start_addr (start_addr),
    .abort      (abort),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_op     (out_op),
    .out_addr   (out_addr),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] addr;
    logic        last;
  } beat_t;

  typedef struct {
    logic [AW-1:0] rd;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp;
  } rvec_t;

  typedef struct {
    logic        valid;
    logic [7:0]  op;
    logic [15:0] addr;
    logic        last;
    logic        done;
    logic        busy;
  } cyc_t;

  beat_t       got_q[$];
  beat_t       exp_q[$];
  logic [31:0] model_mem [DEPTH];
  int          total = 0;
  int          bad   = 0;
  int          done_seen = 0;
  logic        exp_err, exp_done;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Accept is decided on the values present before the edge; done is sampled once per cycle.
  task automatic step();
    beat_t b;
    if (out_valid && out_ready) begin
      b = {out_op, out_addr, out_last};
      got_q.push_back(b);
    end
    @(posedge clk_i);
    #1;
    if (done) done_seen++;
  endtask

  task automatic write_entry(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
    model_mem[a] = d;
  endtask

  // Expected beat list: walk entries from sa until OP_END or the last index.
  task automatic build_expect(input logic [AW-1:0] sa);
    int          p, nb;
    logic [31:0] e;
    beat_t       b;
    exp_q.delete();
    exp_err = 1'b0; exp_done = 1'b0;
    p = int'(sa);
    for (int n = 0; n <= DEPTH; n++) begin
      e = model_mem[p];
      if (e[23:16] == END_OP) begin exp_done = 1'b1; break; end
      nb = (e[31:24] == 8'd0) ? 1 : int'(e[31:24]);
      for (int k = 0; k < nb; k++) begin
        b.op = e[23:16]; b.addr = 16'(int'(e[15:0]) + k); b.last = (k == nb - 1);
        exp_q.push_back(b);
      end
      if (p == DEPTH - 1) begin exp_err = 1'b1; break; end
      p++;
    end
  endtask

  task automatic drain(input string tag, input int pct);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      out_ready = ($urandom_range(0, 99) < pct);
      step();
      n++;
    end
    chk({tag, "_drain_timeout"}, busy, 1'b0);
    out_ready = 1'b0;
  endtask

  task automatic cmp_beats(input string tag);
    chk({tag, "_nbeats"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic launch(input logic [AW-1:0] sa);
    got_q.delete(); done_seen = 0;
    start = 1'b1; start_addr = sa;
    step();
    start = 1'b0;
  endtask

  rvec_t vt[7];
  cyc_t  ct[7];
  beat_t bx;

  initial begin
    rst_n = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; start_addr = '0; abort = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = INIT[i*DW +: DW];

    vt[0] = '{6'd5,  1'b0, 6'd0,  32'h0,         32'h0312_0040};
    vt[1] = '{6'd6,  1'b0, 6'd0,  32'h0,         32'h00FF_0000};
    vt[2] = '{6'd63, 1'b0, 6'd0,  32'h0,         32'h0109_1234};
    vt[3] = '{6'd30, 1'b1, 6'd30, 32'hDEAD_BEEF, 32'h0};
    vt[4] = '{6'd30, 1'b0, 6'd0,  32'h0,         32'hDEAD_BEEF};
    vt[5] = '{6'd31, 1'b1, 6'd30, 32'hCAFE_0001, 32'h0};
    vt[6] = '{6'd30, 1'b0, 6'd0,  32'h0,         32'hCAFE_0001};

    // Cycles T+1..T+7 after a start at 5 with out_ready held high.
    ct[0] = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1};
    ct[1] = '{1'b1, 8'h12, 16'h0040, 1'b0, 1'b0, 1'b1};
    ct[2] = '{1'b1, 8'h12, 16'h0041, 1'b0, 1'b0, 1'b1};
    ct[3] = '{1'b1, 8'h12, 16'h0042, 1'b1, 1'b0, 1'b1};
    ct[4] = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1};
    ct[5] = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1};
    ct[6] = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0};

    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_outs", {dout_o, out_valid, out_op, out_addr, out_last, busy, done, err}, '0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      rd_addr = vt[i].rd; wr_en = vt[i].we; wr_addr = vt[i].wa; wr_data = vt[i].wd;
      step();
      if (vt[i].we) model_mem[vt[i].wa] = vt[i].wd;
      chk($sformatf("rd_vec%0d", i), dout_o, vt[i].exp);
    end
    wr_en = 1'b0;

    // Cycle-exact single entry followed by OP_END.
    out_ready = 1'b1;
    launch(6'd5);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("timed_c%0d_ctl", i + 1), {out_valid, done, busy}, {ct[i].valid, ct[i].done, ct[i].busy});
      if (ct[i].valid)
        chk($sformatf("timed_c%0d_beat", i + 1), {out_op, out_addr, out_last}, {ct[i].op, ct[i].addr, ct[i].last});
      if (i < 6) step();
    end

    // Backpressure on beat 2 with a patch to the in-flight entry.
    launch(6'd5);
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    wr_en = 1'b1; wr_addr = 6'd5; wr_data = 32'h01AA_0000;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stall%0d", i), {out_valid, out_op, out_addr}, {1'b1, 8'h12, 16'h0041});
      step();
      wr_en = 1'b0;
    end
    drain("stall", 100);
    exp_q.delete();
    bx = {8'h12, 16'h0040, 1'b0}; exp_q.push_back(bx);
    bx = {8'h12, 16'h0041, 1'b0}; exp_q.push_back(bx);
    bx = {8'h12, 16'h0042, 1'b1}; exp_q.push_back(bx);
    cmp_beats("stall");
    chk("stall_done", done_seen, 1);
    write_entry(6'd5, 32'h0312_0040);

    // burst_len 0 and address wrap.
    launch(6'd10);
    drain("wrap", 60);
    exp_q.delete();
    bx = {8'h07, 16'hFFFF, 1'b1}; exp_q.push_back(bx);
    bx = {8'h08, 16'hFFFF, 1'b0}; exp_q.push_back(bx);
    bx = {8'h08, 16'h0000, 1'b1}; exp_q.push_back(bx);
    cmp_beats("wrap");
    chk("wrap_done_err", {done_seen[7:0], err}, {8'd1, 1'b0});

    // Pointer overrun at the last index, then err cleared by the next start.
    launch(6'd63);
    drain("ovr", 100);
    exp_q.delete();
    bx = {8'h09, 16'h1234, 1'b1}; exp_q.push_back(bx);
    cmp_beats("ovr");
    chk("ovr_err_nodone", {done_seen[7:0], err}, {8'd0, 1'b1});
    launch(6'd5);
    chk("ovr_err_clear", {err, busy}, 2'b01);
    drain("ovr2", 100);
    chk("ovr2_done", done_seen, 1);

    // Abort mid-issue.
    out_ready = 1'b1;
    launch(6'd20);
    step(); step(); step();
    chk("abort_pre_valid", out_valid, 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle", {out_valid, busy}, 2'b00);
    step(); step(); step();
    chk("abort_quiet", {done_seen[7:0], out_valid, busy, err}, 11'd0);

    // abort and start together in IDLE: start wins.
    abort = 1'b1;
    launch(6'd5);
    abort = 1'b0;
    chk("abort_start_busy", busy, 1'b1);
    drain("abst", 100);
    build_expect(6'd5);
    cmp_beats("abst");
    chk("abst_done", done_seen, 1);

    // Randomised programs and backpressure against the model.
    for (int it = 0; it < 25; it++) begin
      logic [AW-1:0] a, sa;
      logic [7:0]    op, bl;
      logic [15:0]   ad;
      int            pct;
      for (int k = 0; k < 6; k++) begin
        a  = AW'($urandom_range(40, 63));
        op = ($urandom_range(0, 3) == 0) ? END_OP : 8'($urandom_range(0, 254));
        bl = 8'($urandom_range(0, 4));
        ad = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'(32'hFFFD + $urandom_range(0, 3));
        write_entry(a, {bl, op, ad});
      end
      sa  = AW'($urandom_range(40, 63));
      pct = $urandom_range(30, 100);
      build_expect(sa);
      launch(sa);
      drain($sformatf("rnd%0d", it), pct);
      cmp_beats($sformatf("rnd%0d", it));
      chk($sformatf("rnd%0d_end", it), {done_seen[7:0], err}, {7'd0, exp_done, exp_err});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
